paged_hex_display: RTL and testbench

- Parametrised successor to the fixed two-page, 4-digit hex readout of a 32-bit debug word (e.g. CORDIC sine).
- Snapshots a WIDTH-bit value and shows it DIGITS nibbles at a time on a multiplexed 7-segment display.
- Pages advance automatically or by button; optional leading-zero blanking; anti-ghost dead time between digit changes.
- Sits between any debug value source and the PMOD segment/digit-select pins.

---
 rtl/paged_hex_display.sv | 144 ++++++++++++++
 tb/tb_paged_hex_display.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/paged_hex_display.sv
// Snapshots a WIDTH-bit word and pages it DIGITS nibbles at a time onto a multiplexed 7-segment display.
// Segment/digit outputs are registered (1-clock lag). Every digit change is followed by a short all-off gap.
module paged_hex_display #(
  parameter  int WIDTH       = 32,
  parameter  int DIGITS      = 4,
  parameter  int SCAN_DIV    = 14,
  parameter  int PAGE_HOLD   = 24,
  parameter  int DEAD_CYCLES = 4,
  localparam int PAGES       = WIDTH / (4 * DIGITS),
  localparam int PW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              enable,
  input  logic              auto_page,
  input  logic              page_btn,
  input  logic              blank_lz,
  output logic [6:0]        segment,
  output logic [DIGITS-1:0] digit_sel,
  output logic [PW-1:0]     page,
  output logic              page_flag,
  output logic              snap_strobe
);

  localparam int NIB = WIDTH / 4;
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SCAN_DIV-1:0] DEAD      = SCAN_DIV'(DEAD_CYCLES);
  localparam logic [PW-1:0]       LAST_PAGE = PW'(PAGES - 1);
  localparam logic [DW-1:0]       LAST_DIG  = DW'(DIGITS - 1);

  logic [SCAN_DIV-1:0]  scan_cnt;
  logic [DW-1:0]        dig;
  logic [PAGE_HOLD-1:0] hold_cnt;
  logic [WIDTH-1:0]     shadow;
  logic                 btn_q;
  logic                 load_pending;

  logic                 btn_edge;
  logic                 hold_wrap;
  logic                 advance;
  logic                 snap;
  logic [PW-1:0]        page_nxt;
  logic [PAGE_HOLD-1:0] hold_nxt;
  logic [NIB-1:0]       upper_zero;
  logic [3:0]           nib;
  logic                 blank;
  logic [DIGITS-1:0]    dsel;
  logic                 is_dead;
  int                   gi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // A button edge and a hold wrap on the same clock collapse into one advance.
  always_comb begin
    btn_edge  = page_btn & ~btn_q;
    hold_wrap = auto_page & (&hold_cnt);
    advance   = btn_edge | hold_wrap;
    page_nxt  = page;
    if (advance)
      page_nxt = (page == LAST_PAGE) ? '0 : page + 1'b1;
    snap     = load_pending | (advance & (page == LAST_PAGE));
    hold_nxt = (btn_edge | ~auto_page) ? '0 : hold_cnt + 1'b1;
  end

  // upper_zero[n]: nibble n and every nibble above it are zero.
  always_comb begin
    upper_zero        = '0;
    upper_zero[NIB-1] = (shadow[(NIB-1)*4 +: 4] == 4'h0);
    for (int n = NIB - 2; n >= 0; n--)
      upper_zero[n] = upper_zero[n+1] & (shadow[n*4 +: 4] == 4'h0);
  end

  always_comb begin
    gi    = int'(page) * DIGITS + int'(dig);
    nib   = '0;
    blank = 1'b0;
    for (int n = 0; n < NIB; n++) begin
      if (n == gi) begin
        nib   = shadow[n*4 +: 4];
        blank = blank_lz && (n != 0) && upper_zero[n];
      end
    end
    dsel = '0;
    for (int i = 0; i < DIGITS; i++)
      dsel[i] = (int'(dig) == i);
    is_dead = (scan_cnt < DEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt     <= '0;
      dig          <= '0;
      hold_cnt     <= '0;
      shadow       <= '0;
      btn_q        <= 1'b0;
      load_pending <= 1'b1;
      page         <= '0;
      page_flag    <= 1'b0;
      snap_strobe  <= 1'b0;
      segment      <= '0;
      digit_sel    <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt)
        dig <= (dig == LAST_DIG) ? '0 : dig + 1'b1;
      hold_cnt     <= hold_nxt;
      btn_q        <= page_btn;
      load_pending <= 1'b0;
      page         <= page_nxt;
      page_flag    <= (page_nxt != '0);
      snap_strobe  <= snap;
      if (snap)
        shadow <= value;
      if (!enable || is_dead) begin
        segment   <= '0;
        digit_sel <= '0;
      end else begin
        segment   <= blank ? 7'h00 : hex7(nib);
        digit_sel <= dsel;
      end
    end
  end

endmodule

// File: tb/tb_paged_hex_display.sv
// Randomised bench for paged_hex_display: arithmetic reference model feeds a scoreboard queue drained by a monitor.
module tb_paged_hex_display;

  localparam int WIDTH = 32, DIGITS = 4, SCAN_DIV = 3, PAGE_HOLD = 6, DEAD_CYCLES = 1;
  localparam int PAGES    = WIDTH / (4 * DIGITS);
  localparam int PW       = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int SCAN_LEN = 1 << SCAN_DIV;
  localparam int HOLD_LEN = 1 << PAGE_HOLD;

  logic              clk = 0;
  logic              rst_n;
  logic [WIDTH-1:0]  value;
  logic              enable, auto_page, page_btn, blank_lz;
  logic [6:0]        segment;
  logic [DIGITS-1:0] digit_sel;
  logic [PW-1:0]     page;
  logic              page_flag, snap_strobe;

  paged_hex_display #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
    .PAGE_HOLD(PAGE_HOLD), .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .enable(enable),
    .auto_page(auto_page), .page_btn(page_btn), .blank_lz(blank_lz),
    .segment(segment), .digit_sel(digit_sel), .page(page),
    .page_flag(page_flag), .snap_strobe(snap_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]        seg;
    logic [DIGITS-1:0] dsel;
    logic [PW-1:0]     pg;
    logic              flag;
    logic              strobe;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: time since reset release, page, held word, auto-hold age.
  int               cyc, hold, mpage;
  logic [WIDTH-1:0] mshadow;
  bit               mbtn_prev, mload;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, got, expv);
    end
  endtask

  task automatic model_reset();
    cyc = 0; hold = 0; mpage = 0; mshadow = '0; mbtn_prev = 0; mload = 1;
    sb.delete();
  endtask

  // Called just after a negedge with inputs settled; predicts the state after the next posedge.
  task automatic tick();
    exp_t e;
    int scan, digit, g, np;
    bit edge_b, wrap, adv, snap;
    logic [WIDTH-1:0] upper;
    scan  = cyc % SCAN_LEN;
    digit = (cyc / SCAN_LEN) % DIGITS;
    e.seg  = '0;
    e.dsel = '0;
    if (enable && scan >= DEAD_CYCLES) begin
      g      = mpage * DIGITS + digit;
      upper  = mshadow >> (4 * g);
      e.dsel = DIGITS'(1 << digit);
      if (blank_lz && g > 0 && upper == 0) e.seg = 7'h00;
      else                                 e.seg = seg_tab[upper[3:0]];
    end
    wrap   = auto_page && (hold == HOLD_LEN - 1);
    edge_b = page_btn && !mbtn_prev;
    adv    = wrap || edge_b;
    np     = adv ? (mpage + 1) % PAGES : mpage;
    snap   = mload || (adv && mpage == PAGES - 1);
    hold   = (edge_b || !auto_page) ? 0 : (hold + 1) % HOLD_LEN;
    if (snap) mshadow = value;
    mpage = np; mbtn_prev = page_btn; mload = 0; cyc++;
    e.pg = PW'(np); e.flag = (np != 0); e.strobe = snap;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("segment",     32'(segment),     32'(e.seg));
      chk("digit_sel",   32'(digit_sel),   32'(e.dsel));
      chk("page",        32'(page),        32'(e.pg));
      chk("page_flag",   32'(page_flag),   32'(e.flag));
      chk("snap_strobe", 32'(snap_strobe), 32'(e.strobe));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_segment"},   32'(segment),     0);
    chk({tag, "_digit_sel"}, 32'(digit_sel),   0);
    chk({tag, "_page"},      32'(page),        0);
    chk({tag, "_page_flag"}, 32'(page_flag),   0);
    chk({tag, "_strobe"},    32'(snap_strobe), 0);
  endtask

  initial begin
    rst_n = 0; value = 32'h12345678; enable = 1; auto_page = 1; page_btn = 0; blank_lz = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;
    model_reset();

    // Auto paging through page 1, then a new word that must wait for the wrap.
    run(100);
    value = 32'hDEADBEEF;
    run(100);

    // Leading-zero blanking, then an all-zero word.
    blank_lz = 1; value = 32'h000000A3;
    run(140);
    value = 32'h0;
    run(140);

    // Manual paging: long press counts once, second press wraps.
    blank_lz = 0; value = $urandom; auto_page = 0;
    page_btn = 1; run(10);
    page_btn = 0; run(200);
    value = $urandom;
    page_btn = 1; run(2);
    page_btn = 0; run(20);

    // Button edge landing on the hold-wrap clock.
    auto_page = 1;
    for (int i = 0; i < HOLD_LEN + 8 && hold != HOLD_LEN - 1; i++) tick();
    checks++;
    if (hold != HOLD_LEN - 1) begin
      errors++;
      $display("FAIL hold_wrap_wait: got hold %0d expected %0d", hold, HOLD_LEN - 1);
    end
    page_btn = 1; tick();
    page_btn = 0; run(20);

    // Output gating mid-scan.
    run(5);
    enable = 0; run(30);
    enable = 1; run(30);

    // Async reset while on page 1, digit 2.
    for (int i = 0; i < 4 * HOLD_LEN && !(mpage == 1 && (cyc / SCAN_LEN) % DIGITS == 2 && cyc % SCAN_LEN == 4); i++)
      tick();
    checks++;
    if (mpage != 1) begin
      errors++;
      $display("FAIL midreset_wait: got page %0d expected 1", mpage);
    end
    #2 rst_n = 0;
    #1 check_all_zero("async_reset");
    @(negedge clk); @(negedge clk);
    value = $urandom;
    rst_n = 1;
    model_reset();
    run(80);

    // Random soak.
    for (int blk = 0; blk < 8; blk++) begin
      auto_page = $urandom_range(0, 1);
      blank_lz  = $urandom_range(0, 1);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 15) == 0) value = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h0000_0FFF);
        enable = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 7) == 0) page_btn = ~page_btn;
        tick();
      end
    end
    page_btn = 0;
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
